// File: rtl/i2c_frame_sequencer_pkg.sv
// i2c_seq_pkg: shared state type, buffer depth and count encoding for the
// I2C frame sequencer.
package i2c_seq_pkg;

  // Frame buffer depth; matches the parallel data array of the write master.
  localparam int MAX_BYTES = 8;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    REPORT    = 2'd3
  } state_t;

  // Converts a byte count of 1..8 into the master's 3-bit num_bytes field,
  // where a full buffer of 8 is encoded as 0.
  function automatic logic [2:0] encode_count(input logic [3:0] count);
    return (count == 4'd8) ? 3'd0 : count[2:0];
  endfunction

endpackage

// File: rtl/i2c_frame_sequencer_if.sv
// i2c_frame_sequencer_if: byte stream input, parallel frame output to the
// I2C write master, master completion inputs and frame status outputs.
// The master modport is the sequencer side; slave is the environment side.
interface i2c_frame_sequencer_if;
  import i2c_seq_pkg::*;

  logic                      s_valid;
  logic                      s_ready;
  logic [7:0]                s_data;
  logic                      s_last;
  logic [MAX_BYTES-1:0][7:0] data_array;
  logic [2:0]                num_bytes;
  logic                      start;
  logic                      m_busy;
  logic                      m_done;
  logic                      m_ack_error;
  logic                      frame_done;
  logic                      frame_ack_err;
  logic                      frame_trunc;
  logic                      frame_timeout;
  logic                      seq_busy;

  modport master (
    input  s_valid, s_data, s_last, m_busy, m_done, m_ack_error,
    output s_ready, data_array, num_bytes, start,
           frame_done, frame_ack_err, frame_trunc, frame_timeout, seq_busy
  );

  modport slave (
    output s_valid, s_data, s_last, m_busy, m_done, m_ack_error,
    input  s_ready, data_array, num_bytes, start,
           frame_done, frame_ack_err, frame_trunc, frame_timeout, seq_busy
  );

endinterface

// File: rtl/i2c_frame_sequencer_watchdog.sv
// i2c_seq_watchdog: cycle counter that is reloaded to zero by clear_i,
// advances while enable_i is high and flags expired_o on the cycle it holds
// LIMIT-1. A LIMIT of 0 disables expiry entirely.
module i2c_seq_watchdog #(
  parameter int unsigned LIMIT = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Reload has priority over counting so a new frame always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (LIMIT != 0) && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/i2c_frame_sequencer.sv
// i2c_frame_sequencer: packs a valid/ready byte stream into frames of up to
// 8 bytes, launches the I2C write master and reports frame status.
// Optional feature macro I2C_ADDR_PREFIX_EN: slot 0 carries {SLAVE_ADDR,0}
// and the payload fills slots 1..7.
module i2c_frame_sequencer #(
  parameter int          MAX_BYTES      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter logic [6:0]  SLAVE_ADDR     = 7'h50
) (
  input logic                   clk,
  input logic                   rst,
  i2c_frame_sequencer_if.master bus
);
  import i2c_seq_pkg::*;

  if (MAX_BYTES != i2c_seq_pkg::MAX_BYTES) begin : g_bad_depth
    $error("i2c_frame_sequencer: MAX_BYTES must be 8 to match the master array");
  end

  if (SLAVE_ADDR[6:3] == 4'b0000 || SLAVE_ADDR[6:3] == 4'b1111) begin : g_reserved_addr
    $warning("i2c_frame_sequencer: SLAVE_ADDR lies in a reserved I2C address range");
  end

`ifdef I2C_ADDR_PREFIX_EN
  localparam logic [3:0] FIRST_SLOT = 4'd1;
`else
  localparam logic [3:0] FIRST_SLOT = 4'd0;
`endif

  state_t                    state_q, state_d;
  logic [3:0]                wr_cnt_q, wr_cnt_d;
  logic [MAX_BYTES-1:0][7:0] data_q, data_d;
  logic [2:0]                num_bytes_q, num_bytes_d;
  logic                      ack_err_q, ack_err_d;
  logic                      trunc_q, trunc_d;
  logic                      timeout_q, timeout_d;

  logic ready;
  logic launch;
  logic done_pulse;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  i2c_seq_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  // Next-state and output decode; status flags ride along with the frame and
  // are cleared as the report pulse goes out.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    data_d      = data_q;
    num_bytes_d = num_bytes_q;
    ack_err_d   = ack_err_q;
    trunc_d     = trunc_q;
    timeout_d   = timeout_q;
    ready       = 1'b0;
    launch      = 1'b0;
    done_pulse  = 1'b0;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;

    unique case (state_q)
      FILL: begin
        ready = 1'b1;
        if (bus.s_valid) begin
          data_d[wr_cnt_q[2:0]] = bus.s_data;
`ifdef I2C_ADDR_PREFIX_EN
          data_d[0] = {SLAVE_ADDR, 1'b0};
`endif
          wr_cnt_d = wr_cnt_q + 4'd1;
          if (bus.s_last || wr_cnt_q == 4'(MAX_BYTES - 1)) begin
            state_d     = LAUNCH;
            num_bytes_d = encode_count(wr_cnt_q + 4'd1);
            trunc_d     = !bus.s_last;
          end
        end
      end
      LAUNCH: begin
        launch   = 1'b1;
        wd_clear = 1'b1;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_enable = 1'b1;
        if (bus.m_done) begin
          ack_err_d = bus.m_ack_error;
          timeout_d = 1'b0;
          state_d   = REPORT;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = REPORT;
        end
      end
      REPORT: begin
        done_pulse = 1'b1;
        ack_err_d  = 1'b0;
        trunc_d    = 1'b0;
        timeout_d  = 1'b0;
        wr_cnt_d   = FIRST_SLOT;
        state_d    = FILL;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and frame registers; reset discards any buffered frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      wr_cnt_q    <= FIRST_SLOT;
      data_q      <= '0;
      num_bytes_q <= '0;
      ack_err_q   <= 1'b0;
      trunc_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      data_q      <= data_d;
      num_bytes_q <= num_bytes_d;
      ack_err_q   <= ack_err_d;
      trunc_q     <= trunc_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.s_ready       = ready;
  assign bus.start         = launch;
  assign bus.data_array    = data_q;
  assign bus.num_bytes     = num_bytes_q;
  assign bus.frame_done    = done_pulse;
  assign bus.frame_ack_err = done_pulse & ack_err_q;
  assign bus.frame_trunc   = done_pulse & trunc_q;
  assign bus.frame_timeout = done_pulse & timeout_q;
  assign bus.seq_busy      = !(state_q == FILL && wr_cnt_q == FIRST_SLOT);

  // The master is expected to report busy within two cycles of a launch.
  assert property (@(posedge clk) disable iff (rst)
    $past(launch, 2) |-> (bus.m_busy || $past(bus.m_busy)));

endmodule

// File: tb/tb_i2c_frame_sequencer.sv
// tb_i2c_frame_sequencer: directed vectors with hand-computed expectations
// for the I2C frame sequencer, built with a 50-cycle watchdog.
module tb_i2c_frame_sequencer;

  localparam int TIMEOUT = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [7:0] beatBuf [0:15];

  i2c_frame_sequencer_if bus ();

  i2c_frame_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .SLAVE_ADDR    (7'h50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the bench itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] bench stalled");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends beatBuf[0..n-1] back to back; returns at the falling edge after the
  // final accept, which is the cycle the launch pulse should be visible.
  task automatic applyStimulus(input int n, input bit lastOnFinal);
    for (int i = 0; i < n; i++) begin
      checkOutput("readyBeat", {63'd0, bus.s_ready}, 64'd1);
      bus.s_valid = 1'b1;
      bus.s_data  = beatBuf[i];
      bus.s_last  = lastOnFinal && (i == n - 1);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 8'h00;
  endtask

  // Called in the launch cycle: plays the master, pulses done and checks the
  // report and the return to FILL.
  task automatic finishFrame(input bit ackErr, input bit expAck, input bit expTrunc);
    bus.m_busy = 1'b1;
    @(negedge clk);
    checkOutput("startOneShot", {63'd0, bus.start}, 64'd0);
    checkOutput("busyWaiting", {63'd0, bus.seq_busy}, 64'd1);
    checkOutput("readyWaiting", {63'd0, bus.s_ready}, 64'd0);
    @(negedge clk);
    bus.m_done      = 1'b1;
    bus.m_ack_error = ackErr;
    @(negedge clk);
    bus.m_done      = 1'b0;
    bus.m_ack_error = 1'b0;
    checkOutput("frameDone", {63'd0, bus.frame_done}, 64'd1);
    checkOutput("frameAckErr", {63'd0, bus.frame_ack_err}, {63'd0, expAck});
    checkOutput("frameTrunc", {63'd0, bus.frame_trunc}, {63'd0, expTrunc});
    checkOutput("frameTimeout", {63'd0, bus.frame_timeout}, 64'd0);
    checkOutput("readyReport", {63'd0, bus.s_ready}, 64'd0);
    @(negedge clk);
    bus.m_busy = 1'b0;
    checkOutput("readyAfterDone", {63'd0, bus.s_ready}, 64'd1);
    checkOutput("doneOneShot", {63'd0, bus.frame_done}, 64'd0);
  endtask

  task automatic checkResetValues();
    checkOutput("rstReady", {63'd0, bus.s_ready}, 64'd1);
    checkOutput("rstStart", {63'd0, bus.start}, 64'd0);
    checkOutput("rstNumBytes", {61'd0, bus.num_bytes}, 64'd0);
    checkOutput("rstData", bus.data_array, 64'd0);
    checkOutput("rstFrameFlags", {60'd0, bus.frame_done, bus.frame_ack_err,
                                  bus.frame_trunc, bus.frame_timeout}, 64'd0);
    checkOutput("rstSeqBusy", {63'd0, bus.seq_busy}, 64'd0);
  endtask

  initial begin
    int cycles;
    int seenDone;

    bus.s_valid     = 1'b0;
    bus.s_data      = 8'h00;
    bus.s_last      = 1'b0;
    bus.m_busy      = 1'b0;
    bus.m_done      = 1'b0;
    bus.m_ack_error = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues();
    rst = 1'b0;
    @(negedge clk);
    checkResetValues();

`ifndef I2C_ADDR_PREFIX_EN
    // Three-byte frame, last on the third beat.
    beatBuf[0] = 8'hA1; beatBuf[1] = 8'hB2; beatBuf[2] = 8'hC3;
    applyStimulus(3, 1'b1);
    checkOutput("start3", {63'd0, bus.start}, 64'd1);
    checkOutput("numBytes3", {61'd0, bus.num_bytes}, 64'd3);
    checkOutput("slots3", {40'd0, bus.data_array[23:0]}, 64'h00C3B2A1);
    finishFrame(1'b0, 1'b0, 1'b0);
    checkOutput("heldData3", {40'd0, bus.data_array[23:0]}, 64'h00C3B2A1);
    checkOutput("heldNum3", {61'd0, bus.num_bytes}, 64'd3);
    checkOutput("idleSeqBusy", {63'd0, bus.seq_busy}, 64'd0);

    // Full eight-byte frame with last on the eighth beat.
    for (int i = 0; i < 8; i++) beatBuf[i] = 8'(i);
    applyStimulus(8, 1'b1);
    checkOutput("start8", {63'd0, bus.start}, 64'd1);
    checkOutput("numBytes8", {61'd0, bus.num_bytes}, 64'd0);
    checkOutput("slots8", bus.data_array, 64'h0706050403020100);
    finishFrame(1'b0, 1'b0, 1'b0);

    // Eight beats without last: truncated, ninth beat opens a new frame.
    for (int i = 0; i < 9; i++) beatBuf[i] = 8'h10 + 8'(i);
    applyStimulus(8, 1'b0);
    checkOutput("startTrunc", {63'd0, bus.start}, 64'd1);
    checkOutput("numBytesTrunc", {61'd0, bus.num_bytes}, 64'd0);
    checkOutput("slotsTrunc", bus.data_array, 64'h1716151413121110);
    finishFrame(1'b0, 1'b0, 1'b1);
    beatBuf[0] = 8'h18;
    applyStimulus(1, 1'b1);
    checkOutput("startNinth", {63'd0, bus.start}, 64'd1);
    checkOutput("slot0Ninth", {56'd0, bus.data_array[0]}, 64'h18);
    checkOutput("numBytesNinth", {61'd0, bus.num_bytes}, 64'd1);
    finishFrame(1'b0, 1'b0, 1'b0);

    // Master reports a NACK.
    beatBuf[0] = 8'h5A;
    applyStimulus(1, 1'b1);
    checkOutput("startNack", {63'd0, bus.start}, 64'd1);
    finishFrame(1'b1, 1'b1, 1'b0);

    // Master never completes: watchdog ends the frame 51 cycles after start.
    beatBuf[0] = 8'h3C;
    applyStimulus(1, 1'b1);
    checkOutput("startTimeout", {63'd0, bus.start}, 64'd1);
    bus.m_busy = 1'b1;
    cycles = 0;
    while (!bus.frame_done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("timeoutLatency", 64'(cycles), 64'd51);
    checkOutput("timeoutFlag", {63'd0, bus.frame_timeout}, 64'd1);
    checkOutput("timeoutAckErr", {63'd0, bus.frame_ack_err}, 64'd0);
    @(negedge clk);
    bus.m_busy = 1'b0;
    checkOutput("readyAfterTimeout", {63'd0, bus.s_ready}, 64'd1);

    // Reset during WAIT_DONE discards the frame; a later done is ignored.
    beatBuf[0] = 8'h77; beatBuf[1] = 8'h88;
    applyStimulus(2, 1'b1);
    checkOutput("startRst", {63'd0, bus.start}, 64'd1);
    bus.m_busy = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("waitBeforeRst", {63'd0, bus.s_ready}, 64'd0);
    rst = 1'b1;
    #1;
    checkResetValues();
    @(negedge clk);
    rst = 1'b0;
    bus.m_busy = 1'b0;
    @(negedge clk);
    bus.m_done      = 1'b1;
    bus.m_ack_error = 1'b1;
    @(negedge clk);
    bus.m_done      = 1'b0;
    bus.m_ack_error = 1'b0;
    seenDone = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.frame_done) seenDone++;
      @(negedge clk);
    end
    checkOutput("noDoneAfterRst", 64'(seenDone), 64'd0);
    checkOutput("readyAfterRst", {63'd0, bus.s_ready}, 64'd1);
`else
    // Address prefix: slot 0 carries {0x50,0}, payload follows.
    beatBuf[0] = 8'h11; beatBuf[1] = 8'h22;
    applyStimulus(2, 1'b1);
    checkOutput("startPrefix", {63'd0, bus.start}, 64'd1);
    checkOutput("numBytesPrefix", {61'd0, bus.num_bytes}, 64'd3);
    checkOutput("slotsPrefix", {40'd0, bus.data_array[23:0]}, 64'h002211A0);
    finishFrame(1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/i2c_frame_sequencer.md
Name: i2c_frame_sequencer

Overview:
- Upstream feeder for the simple I2C write master.
- Accepts a byte stream (valid/ready with last) and packs up to 8 bytes into the master's parallel data array, then pulses the master's start.
- Waits for the master's done pulse, then reports frame status (ACK error, truncation, timeout).
- Only one frame is in flight at a time. The stream is back-pressured while a frame is being sent.

Parameters:
- MAX_BYTES, 8, frame buffer depth. Fixed at 8 to match the master's array; any other value is a synthesis-time error.
- TIMEOUT_CYCLES, 200000, clk cycles allowed between the start pulse and the master's done. 0 disables the watchdog.
- SLAVE_ADDR, 7'h50, 7-bit target address. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input byte valid
- s_ready  out  1  sequencer can accept a byte this cycle
- s_data  in  8  input byte
- s_last  in  1  marks the final byte of a frame
- data_array  out  8x[7:0]  packed frame to master; slot 0 is transmitted first
- num_bytes  out  3  byte count to master, modulo 8 (0 encodes 8)
- start  out  1  one-cycle launch pulse to master
- m_busy  in  1  master busy
- m_done  in  1  master done pulse
- m_ack_error  in  1  master ACK error flag; sampled with m_done
- frame_done  out  1  one-cycle pulse when the frame completes, with or without error
- frame_ack_err  out  1  valid with frame_done; NACK seen during the frame
- frame_trunc  out  1  valid with frame_done; the buffer filled before s_last arrived
- frame_timeout  out  1  valid with frame_done; watchdog expired
- seq_busy  out  1  high in any state other than FILL-with-count-0

Behaviour:
- Reset values: s_ready=1, start=0, num_bytes=0, all data_array slots=0, all frame_* outputs=0, state=FILL, wr_cnt=0, timer=0.
- A byte is accepted when s_valid && s_ready. It is written to slot wr_cnt, and wr_cnt increments.
- State FILL:
  - s_ready=1.
  - An accept with s_last=1 or wr_cnt==7 goes to LAUNCH on the next cycle.
  - If the 8th byte is accepted with s_last=0, trunc_flag is set. Further bytes of that upstream frame open a new frame.
- State LAUNCH (1 cycle):
  - s_ready=0, start=1.
  - num_bytes = total count[2:0]; 8 bytes gives 0.
  - data_array and num_bytes are held stable from LAUNCH until the next FILL accept.
  - Timer is cleared. Next state is WAIT_DONE.
- State WAIT_DONE:
  - s_ready=0; timer increments each cycle.
  - m_done=1 goes to REPORT and latches ack_err = m_ack_error.
  - If TIMEOUT_CYCLES!=0 and timer reaches TIMEOUT_CYCLES-1 with no m_done, go to REPORT with timeout_flag=1.
  - m_done on the same cycle as expiry counts as a normal completion; timeout_flag=0.
- State REPORT (1 cycle):
  - frame_done=1; frame_ack_err, frame_trunc and frame_timeout are driven from the latched flags.
  - Clears flags and wr_cnt. Next state is FILL.
- Latency:
  - Accept of the last byte to start = 1 cycle.
  - m_done to frame_done = 1 cycle.
  - frame_done to s_ready=1 = 1 cycle.
- m_done or m_ack_error outside WAIT_DONE is ignored.
- m_busy does not gate transitions. It only feeds an assertion: m_busy must rise within 2 cycles after start.
- Reset asserted mid-frame:
  - Returns immediately to reset values; the buffered frame is discarded.
  - start is never glitched high during reset.

Optional Feature:
- Macro I2C_ADDR_PREFIX_EN.
- Defined:
  - Slot 0 is preloaded with {SLAVE_ADDR,1'b0} when entering FILL; payload bytes start at slot 1.
  - The buffer is full after 7 payload bytes; wr_cnt starts at 1.
  - num_bytes includes the address byte.
- Not defined: payload starts at slot 0, 8 payload bytes maximum.

Decomposition:
- Package i2c_seq_pkg holds:
  - the state_t enum (FILL, LAUNCH, WAIT_DONE, REPORT);
  - MAX_BYTES;
  - the count-encoding helper function (count 1..8 to 3-bit num_bytes).
- One sub-module, i2c_seq_watchdog: a loadable cycle counter with clear/enable and an expired output.

Test Plan:
- 3 beats 0xA1,0xB2,0xC3, last on the 3rd -> start 1 cycle later; slots 0..2 = A1,B2,C3; num_bytes=3. m_done with ack=0 -> frame_done with all flags 0.
- 8 beats 0x00..0x07, last on the 8th -> num_bytes=0, frame_trunc=0. With last=0 on the 8th -> frame_trunc=1 on frame_done; the 9th beat starts a new frame at slot 0.
- m_done with m_ack_error=1 -> frame_ack_err=1, then s_ready=1 one cycle after frame_done.
- TIMEOUT_CYCLES=50, never drive m_done -> frame_done and frame_timeout=1 exactly 51 cycles after start.
- rst pulse during WAIT_DONE -> all outputs at reset values, s_ready=1; a later m_done is ignored and produces no frame_done.
- I2C_ADDR_PREFIX_EN with SLAVE_ADDR=7'h50 and 2 beats 0x11,0x22 -> slots A0,11,22; num_bytes=3.
